// File: rtl/dsp_sys_ws.sv
// dsp_sys_ws: weight-stationary systolic MAC array with weight preload, input skew, output deskew and backpressure stall
module dsp_sys_ws #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ACT_DW = 8,
  parameter int WGT_DW = 8,
  parameter int PSU_DW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wgt_valid,
  output logic                     wgt_ready,
  input  logic [COLS*WGT_DW-1:0]   wgt_in,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [ROWS*ACT_DW-1:0]   act_in,
  output logic                     psu_valid,
  input  logic                     psu_ready,
  output logic [COLS*PSU_DW-1:0]   psu_out,
  output logic                     busy
);
  localparam int L  = ROWS + COLS;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(L + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] cnt;
  logic [L-1:0] vp;
  logic en, acc, emit, wacc;
  logic signed [WGT_DW-1:0] w [ROWS][COLS];
  logic signed [ACT_DW-1:0] a_in [ROWS][COLS];
  logic signed [ACT_DW-1:0] a_reg [ROWS][COLS];
  logic signed [PSU_DW-1:0] p_in [ROWS][COLS];
  logic signed [PSU_DW-1:0] p_reg [ROWS][COLS];
  logic signed [PSU_DW-1:0] dsk [COLS];
  logic signed [PSU_DW-1:0] oq [COLS];

  assign en = !(vp[L-1] && !psu_ready);
  assign wgt_ready = !rst && (state == IDLE || state == LOAD);
  assign act_ready = !rst && state == RUN && en;
  assign psu_valid = !rst && vp[L-1];
  assign busy = !rst && (state != IDLE || cnt != '0);
  assign wacc = wgt_valid && wgt_ready;
  assign acc = act_valid && act_ready;
  assign emit = psu_valid && psu_ready;

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      row <= '0;
    end else case (state)
      IDLE, LOAD: if (wgt_valid) begin
        state <= row == RW'(ROWS - 1) ? RUN : LOAD;
        row <= row == RW'(ROWS - 1) ? '0 : row + RW'(1);
      end
      RUN: if (wgt_valid) state <= DRAIN;
      default: if (cnt == '0) state <= LOAD;
    endcase

  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      vp <= '0;
    end else begin
      cnt <= cnt + CW'(acc) - CW'(emit);
      if (en) vp <= {vp[L-2:0], acc};
    end

  always_ff @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rst) w[r][c] <= '0;
        else if (wacc && row == RW'(r)) w[r][c] <= wgt_in[c*WGT_DW +: WGT_DW];

  // Bubbles carry zero activations so idle slots never disturb the sums
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [ACT_DW-1:0] a0;
    assign a0 = acc ? act_in[r*ACT_DW +: ACT_DW] : '0;
    if (r == 0) begin : g_ns
      assign a_in[r][0] = a0;
    end else begin : g_sk
      logic signed [ACT_DW-1:0] sk [r];
      always_ff @(posedge clk)
        if (rst) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else if (en) begin
          sk[0] <= a0;
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      assign a_in[r][0] = sk[r-1];
    end
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      if (c > 0) begin : g_ar
        assign a_in[r][c] = a_reg[r][c-1];
      end
      if (r == 0) begin : g_p0
        assign p_in[r][c] = '0;
      end else begin : g_pn
        assign p_in[r][c] = p_reg[r-1][c];
      end
    end
  end

  always_ff @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rst) begin
          p_reg[r][c] <= '0;
          a_reg[r][c] <= '0;
        end else if (en) begin
          p_reg[r][c] <= p_in[r][c] + PSU_DW'(a_in[r][c]) * PSU_DW'(w[r][c]);
          a_reg[r][c] <= a_in[r][c];
        end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_nd
      assign dsk[c] = p_reg[ROWS-1][c];
    end else begin : g_dl
      logic signed [PSU_DW-1:0] dl [D];
      always_ff @(posedge clk)
        if (rst) begin
          for (int i = 0; i < D; i++) dl[i] <= '0;
        end else if (en) begin
          dl[0] <= p_reg[ROWS-1][c];
          for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
        end
      assign dsk[c] = dl[D-1];
    end
    assign psu_out[c*PSU_DW +: PSU_DW] = rst ? '0 : oq[c];
  end

  always_ff @(posedge clk)
    for (int c = 0; c < COLS; c++)
      if (rst) oq[c] <= '0;
      else if (en) oq[c] <= dsk[c];
endmodule

// File: tb/tb_dsp_sys_ws.sv
// tb_dsp_sys_ws: directed stimulus against a queue-based behavioural model plus literal checks on three builds
module tb_dsp_sys_ws;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic wv = 0, av = 0, pr = 1;
  logic [31:0] wd = '0, ad = '0;
  logic wgt_ready, act_ready, psu_valid, busy;
  logic [127:0] psu_out;
  logic b_wv = 0, b_av = 0, b_pr = 1;
  logic [31:0] b_wd = '0, b_ad = '0;
  logic b_wr, b_ar, b_pv, b_bz;
  logic [63:0] b_po;
  logic c_wv = 0, c_av = 0, c_pr = 1;
  logic [7:0] c_wd = '0, c_ad = '0;
  logic c_wr, c_ar, c_pv, c_bz;
  logic [31:0] c_po;
  int nvec = 0, nerr = 0;

  dsp_sys_ws dut (.clk(clk), .rst(rst), .wgt_valid(wv), .wgt_ready(wgt_ready), .wgt_in(wd),
    .act_valid(av), .act_ready(act_ready), .act_in(ad), .psu_valid(psu_valid), .psu_ready(pr),
    .psu_out(psu_out), .busy(busy));
  dsp_sys_ws #(.PSU_DW(16)) dut_b (.clk(clk), .rst(rst), .wgt_valid(b_wv), .wgt_ready(b_wr),
    .wgt_in(b_wd), .act_valid(b_av), .act_ready(b_ar), .act_in(b_ad), .psu_valid(b_pv),
    .psu_ready(b_pr), .psu_out(b_po), .busy(b_bz));
  dsp_sys_ws #(.ROWS(1), .COLS(1)) dut_c (.clk(clk), .rst(rst), .wgt_valid(c_wv), .wgt_ready(c_wr),
    .wgt_in(c_wd), .act_valid(c_av), .act_ready(c_ar), .act_in(c_ad), .psu_valid(c_pv),
    .psu_ready(c_pr), .psu_out(c_po), .busy(c_bz));

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  typedef struct packed { logic [3:0][31:0] res; int age; } ent_t;
  ent_t q[$];
  int wm [4][4];
  int ph = 0, wrow = 0;

  always @(negedge clk) begin
    ent_t e;
    bit ev, en, ar;
    int s, dr;
    ev = !rst && q.size() > 0 && q[0].age == 8;
    en = !(ev && !pr);
    ar = !rst && ph == 2 && en;
    chk("psu_valid", psu_valid, ev);
    chk("act_ready", act_ready, ar);
    chk("wgt_ready", wgt_ready, !rst && ph <= 1);
    chk("busy", busy, !rst && (ph != 0 || q.size() != 0));
    if (ev) for (int c = 0; c < 4; c++) chk("psu_out", psu_out[c*32 +: 32], q[0].res[c]);
    if (rst) chk("psu_out_rst", psu_out, 0);
    if (rst) begin
      ph = 0;
      wrow = 0;
      q.delete();
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wm[r][c] = 0;
    end else begin
      dr = q.size();
      if (en) begin
        if (ev && pr) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (av && ar) begin
          e.age = 1;
          for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int r = 0; r < 4; r++) s += $signed(ad[r*8 +: 8]) * wm[r][c];
            e.res[c] = s;
          end
          q.push_back(e);
        end
      end
      if (ph <= 1) begin
        if (wv) begin
          for (int c = 0; c < 4; c++) wm[wrow][c] = $signed(wd[c*8 +: 8]);
          wrow++;
          ph = wrow == 4 ? 2 : 1;
          if (wrow == 4) wrow = 0;
        end
      end else if (ph == 2) begin
        if (wv) ph = 3;
      end else if (dr == 0) ph = 1;
    end
  end

  function automatic logic [31:0] mk(input int base, input int step);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(base + k * step);
    return v;
  endfunction

  task automatic send_w(input logic [31:0] d);
    logic ok;
    wv = 1;
    wd = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = wgt_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        wv = 0;
        return;
      end
    end
    nvec++;
    nerr++;
    $display("FAIL w_accept: wgt_ready never seen, required within 60 cycles");
    wv = 0;
  endtask

  task automatic send_a(input logic [31:0] d);
    logic ok;
    av = 1;
    ad = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = act_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        av = 0;
        return;
      end
    end
    nvec++;
    nerr++;
    $display("FAIL a_accept: act_ready never seen, required within 60 cycles");
    av = 0;
  endtask

  task automatic wait_out(input string n, input int lat, input logic [127:0] exp);
    int k;
    k = 1;
    while (!psu_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({n, "_lat"}, k, lat);
    chk(n, psu_out, exp);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int r = 0; r < 4; r++) send_w(32'h1 << (r * 8));
    send_a(32'h04030201);
    wait_out("identity", 8, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int r = 0; r < 4; r++) send_w(32'hFFFFFFFF);
    send_a(32'h7F7F7F7F);
    wait_out("neg508", 8, {4{32'hFFFFFE04}});
    for (int r = 0; r < 4; r++) send_w(mk(r * 4 - 7, 1));
    fork
      for (int i = 0; i < 10; i++) send_a(mk(i * 29 - 90, 53));
      begin
        repeat (11) @(posedge clk);
        #1 pr = 0;
        repeat (3) @(posedge clk);
        #1 pr = 1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    send_a(mk(5, -3));
    send_a(mk(-40, 17));
    wv = 1;
    wd = 32'h02020202;
    send_a(mk(100, -61));
    for (int r = 0; r < 4; r++) send_w(32'h02020202);
    send_a(32'h01010101);
    wait_out("reload", 8, {4{32'd8}});
    for (int i = 0; i < 5; i++) send_a(mk(i * 7 + 1, 9));
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", psu_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wgt_ready", wgt_ready, 1);
    @(posedge clk);
    #1;
    b_wv = 1;
    b_wd = 32'h7F7F7F7F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_wgt_ready", b_wr, 1);
      @(posedge clk);
      #1;
    end
    b_wv = 0;
    b_av = 1;
    b_ad = 32'h7F7F7F7F;
    @(negedge clk);
    chk("b_act_ready", b_ar, 1);
    @(posedge clk);
    #1 b_av = 0;
    k = 1;
    while (!b_pv && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("b_lat", k, 8);
    chk("b_wrap", b_po, {4{16'hFC04}});
    c_wv = 1;
    c_wd = 8'h03;
    @(negedge clk);
    chk("c_wgt_ready", c_wr, 1);
    @(posedge clk);
    #1 c_wv = 0;
    c_av = 1;
    c_ad = 8'hFC;
    @(negedge clk);
    chk("c_act_ready", c_ar, 1);
    @(posedge clk);
    #1 c_av = 0;
    k = 1;
    while (!c_pv && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("c_lat", k, 2);
    chk("c_prod", c_po, 32'hFFFFFFF4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dsp_sys_ws.md
Name: dsp_sys_ws

Overview:
- Parametrised weight-stationary systolic MAC array; successor to the fixed-geometry DSP systolic array.
- Adds:
  - an explicit weight-preload phase with valid/ready handshakes;
  - built-in input skew and output deskew;
  - whole-array stall under output backpressure;
  - a safe drain-before-reload sequence.
- Sits between the shared activation buffer and the partial-sum writeback path.

Parameters:
ROWS, 4, array rows (reduction depth); >=1
COLS, 4, array columns (output channels); >=1
ACT_DW, 8, signed activation width
WGT_DW, 8, signed weight width
PSU_DW, 32, signed partial-sum width; >= ACT_DW+WGT_DW; overflow wraps modulo 2^PSU_DW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wgt_valid  in  1  weight beat valid
wgt_ready  out  1  weight beat accepted when wgt_valid&&wgt_ready
wgt_in  in  COLS*WGT_DW  one weight row, element c -> column c
act_valid  in  1  activation vector valid
act_ready  out  1  activation vector accepted when act_valid&&act_ready
act_in  in  ROWS*ACT_DW  one activation vector, element r -> array row r
psu_valid  out  1  output vector valid
psu_ready  in  1  downstream ready
psu_out  out  COLS*PSU_DW  psu_out[c] = sum_r act[r]*W[r][c]
busy  out  1  high when state != IDLE or in-flight count != 0

Behaviour:
- Reset value of every output:
  - rst has priority over all inputs and clears state to IDLE, all weights to 0, skew/deskew/PE pipelines and the in-flight counter to 0.
  - While rst is high: wgt_ready=0, act_ready=0, psu_valid=0, psu_out=0, busy=0.
  - First cycle after rst falls: wgt_ready=1.
  - Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE: wgt_ready=1, act_ready=0. First accepted beat is written to row 0, then -> LOAD. If ROWS==1, -> RUN instead.
  - LOAD: wgt_ready=1. Beat k is written to row k (k counts 1..ROWS-1). After the beat for row ROWS-1 -> RUN. act_ready=0.
  - RUN: wgt_ready=0, act_ready=en. wgt_valid high -> DRAIN (that beat is not accepted).
  - DRAIN: act_ready=0, wgt_ready=0. When in-flight==0 -> LOAD with row counter 0; the next beat writes row 0.
  - Weights are changed only in IDLE/LOAD, never while vectors are in flight.
- Pipeline enable: en = !(psu_valid && !psu_ready).
  - When en=0, every skew, PE and deskew register and the valid pipeline hold; no data is lost or duplicated.
- Datapath:
  - Row r activation is delayed r cycles by the skew line, then flows right through one register per PE.
  - Partial sums flow down, one register per PE, starting from 0 at row 0.
  - Column c output is delayed COLS-1-c cycles by the deskew line so all columns align.
- Latency: a vector accepted at enabled cycle t appears with psu_valid=1 at t+ROWS+COLS enabled cycles.
- Throughput: one vector per cycle when unstalled.
- Output register: psu_out holds its value while psu_valid && !psu_ready.
- Arithmetic:
  - Signed two's complement; products sign-extended to PSU_DW.
  - Additions wrap, no saturation.
- In-flight counter: +1 on act accept, -1 on psu_valid&&psu_ready; same-cycle accept and emit leaves it unchanged. Maximum value is ROWS+COLS.
- Simultaneous wgt_valid and act_valid in RUN: the act vector is accepted that cycle and transition to DRAIN happens at the same clock edge.
- In IDLE/LOAD, act_valid is ignored (act_ready=0).

Test Plan:
- Identity load (W[r][c]=1 if r==c), act_in={1,2,3,4} accepted at cycle t, psu_ready=1 -> psu_valid at t+8, psu_out={1,2,3,4}.
- All W=-1, act={127,127,127,127} -> psu_out[c]=-508 for all c. Same test with PSU_DW=16, W=127, act=127 -> each column 16'hFC04 (wrapped).
- Back-to-back 10 vectors with psu_ready held low for 3 cycles mid-stream -> act_ready low those cycles; all 10 results emerge in order with no loss or duplication; psu_out stable while stalled.
- wgt_valid asserted in RUN with 3 vectors in flight -> act_ready drops; 3 results emerge computed with old weights; then wgt_ready=1; new weights (all 2) applied to the next vector {1,1,1,1} -> {8,8,8,8}.
- rst pulsed while 5 vectors are in flight -> no psu_valid afterwards; busy=0; weights read back as zero (any vector after reload-free RUN impossible; state is IDLE with wgt_ready=1).
- ROWS=1, COLS=1 build: single weight beat -> RUN; latency 2; 3*(-4) -> -12.
